ctu_clsp_clkgn_divctl: RTL and testbench

- Frequency-change sequencer for one CTU clock-domain divider (the 1-div clock generator).
- Accepts a divide-decode request from CTU control and checks that each mux-select group is zero-or-one-hot.
- Sequences the divider through stretch, init-load and edge-alignment, driving its div_dec, stretch_l and init_l.
- Returns a done/error handshake to the requester.

---
 rtl/ctu_clsp_clkgn_divctl_if.sv | 25 ++
 rtl/ctu_clsp_clkgn_divctl.sv | 237 +++++++++++++++++++++++
 tb/tb_ctu_clsp_clkgn_divctl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ctu_clsp_clkgn_divctl_if.sv
// Change-request handshake between CTU control (master) and the 1-div
// clock-generator divider sequencer (slave).
interface ctu_clsp_clkgn_divctl_if;
  logic        chg_req;      // level, held by requester until chg_ack
  logic [14:0] chg_div_dec;  // requested divider decode
  logic        chg_ack;      // one-cycle completion pulse
  logic        chg_err;      // qualified by chg_ack
  logic        busy;         // sequencer not idle

  modport master (
    output chg_req,
    output chg_div_dec,
    input  chg_ack,
    input  chg_err,
    input  busy
  );

  modport slave (
    input  chg_req,
    input  chg_div_dec,
    output chg_ack,
    output chg_err,
    output busy
  );
endinterface

// File: rtl/ctu_clsp_clkgn_divctl.sv
// Frequency-change sequencer for one CTU 1-div clock-generator divider.
// Accepts a divide-decode request, checks that each mux-select group is
// zero-or-one-hot, then walks the divider through stretch, init-load and
// edge alignment before returning a done/error handshake.
// Optional build macro CTU_DIVCTL_TIMEOUT_EN adds a WAIT_ALIGN watchdog that
// completes the change with an error after TMO_CYC cycles without alignment.
module ctu_clsp_clkgn_divctl #(
  parameter int unsigned STRETCH_CYC = 4,
  parameter int unsigned INIT_CYC    = 2,
  parameter int unsigned ALIGN_EDGES = 2,
  parameter logic [14:0] RST_DIV_DEC = 15'h0000,
  parameter int unsigned TMO_CYC     = 255
) (
  input  logic                          pll_clk,
  input  logic                          rst_l,
  ctu_clsp_clkgn_divctl_if.slave        ctl,
  input  logic                          align_edge,
  output logic [14:0]                   div_dec,
  output logic                          stretch_l,
  output logic                          init_l
);

  // Elaboration-time guard on the 8-bit counter ranges.
  if (STRETCH_CYC < 1 || STRETCH_CYC > 255 ||
      INIT_CYC    < 1 || INIT_CYC    > 255 ||
      ALIGN_EDGES < 1 || ALIGN_EDGES > 255 ||
      TMO_CYC     < 1 || TMO_CYC     > 255) begin : g_bad_param
    $error("ctu_clsp_clkgn_divctl: cycle parameters must lie in 1..255");
  end

  // Terminal counts: the counter holds (cycles already spent - 1) on the
  // cycle that completes a phase.
  localparam logic [7:0] STRETCH_LAST = 8'(STRETCH_CYC - 1);
  localparam logic [7:0] INIT_LAST    = 8'(INIT_CYC - 1);
  localparam logic [7:0] ALIGN_LAST   = 8'(ALIGN_EDGES - 1);
`ifdef CTU_DIVCTL_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST     = 8'(TMO_CYC - 1);
`endif

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_IDLE,
    ST_CHECK,
    ST_STRETCH,
    ST_LOAD,
    ST_WAIT_ALIGN,
    ST_DONE,
    ST_HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [14:0] shadow_q, shadow_d;
  logic        err_q, err_d;
  logic [14:0] div_dec_q, div_dec_d;
  logic        stretch_l_q, stretch_l_d;
  logic        init_l_q, init_l_d;
  logic        chg_ack_q, chg_ack_d;
  logic        chg_err_q, chg_err_d;
  logic        busy_q, busy_d;
`ifdef CTU_DIVCTL_TIMEOUT_EN
  logic [7:0]  wdog_q, wdog_d;
`endif

  // A select group is acceptable when at most one bit is set.
  function automatic logic group_ok(input logic [3:0] g);
    return (g & (g - 4'd1)) == 4'd0;
  endfunction

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic shadow_legal;
  assign shadow_legal = group_ok({1'b0, shadow_q[11:9]}) &&
                        group_ok(shadow_q[4:1]) &&
                        group_ok(shadow_q[8:5]);

  // Next-state and next-output decode for the change sequence.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned and no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    err_d       = err_q;
    div_dec_d   = div_dec_q;
    stretch_l_d = stretch_l_q;
    init_l_d    = init_l_q;
    chg_ack_d   = 1'b0;
    chg_err_d   = 1'b0;
`ifdef CTU_DIVCTL_TIMEOUT_EN
    wdog_d      = wdog_q;
`endif

    case (state_q)
      ST_BOOT: begin
        if (cnt_q == INIT_LAST) begin
          init_l_d = 1'b1;
          cnt_d    = 8'd0;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end

      ST_IDLE: begin
        if (ctl.chg_req) begin
          shadow_d = ctl.chg_div_dec;
          state_d  = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (shadow_legal) begin
          err_d       = 1'b0;
          stretch_l_d = 1'b0;
          cnt_d       = 8'd0;
          state_d     = ST_STRETCH;
        end else begin
          // Rejected: the divider outputs are left exactly as they were.
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_STRETCH: begin
        if (cnt_q == STRETCH_LAST) begin
          div_dec_d = shadow_q;
          init_l_d  = 1'b0;
          cnt_d     = 8'd0;
          state_d   = ST_LOAD;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end

      ST_LOAD: begin
        if (cnt_q == INIT_LAST) begin
          // Release init and stretch together so the divider restarts cleanly.
          init_l_d    = 1'b1;
          stretch_l_d = 1'b1;
          cnt_d       = 8'd0;
`ifdef CTU_DIVCTL_TIMEOUT_EN
          wdog_d      = 8'd0;
`endif
          state_d     = ST_WAIT_ALIGN;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end

      ST_WAIT_ALIGN: begin
        if (align_edge && (cnt_q == ALIGN_LAST)) begin
          // The final edge wins over a coincident watchdog expiry.
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else begin
          if (align_edge) begin
            cnt_d = sat_inc(cnt_q);
          end
`ifdef CTU_DIVCTL_TIMEOUT_EN
          if (wdog_q == TMO_LAST) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            wdog_d = sat_inc(wdog_q);
          end
`endif
        end
      end

      ST_DONE: begin
        chg_ack_d = 1'b1;
        chg_err_d = err_q;
        state_d   = ST_HOLD;
      end

      ST_HOLD: begin
        // Requester must show chg_req low before another change is taken.
        if (!ctl.chg_req) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered-output update; reset restarts the boot init pulse.
  always_ff @(posedge pll_clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= ST_BOOT;
      cnt_q       <= 8'd0;
      shadow_q    <= 15'd0;
      err_q       <= 1'b0;
      div_dec_q   <= RST_DIV_DEC;
      stretch_l_q <= 1'b1;
      init_l_q    <= 1'b0;
      chg_ack_q   <= 1'b0;
      chg_err_q   <= 1'b0;
      busy_q      <= 1'b1;
`ifdef CTU_DIVCTL_TIMEOUT_EN
      wdog_q      <= 8'd0;
`endif
    end else begin
      // NOTE: non-blocking assignments make every register take its value
      // from pre-edge state, so statement order here never matters.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      err_q       <= err_d;
      div_dec_q   <= div_dec_d;
      stretch_l_q <= stretch_l_d;
      init_l_q    <= init_l_d;
      chg_ack_q   <= chg_ack_d;
      chg_err_q   <= chg_err_d;
      busy_q      <= busy_d;
`ifdef CTU_DIVCTL_TIMEOUT_EN
      wdog_q      <= wdog_d;
`endif
    end
  end

  assign div_dec     = div_dec_q;
  assign stretch_l   = stretch_l_q;
  assign init_l      = init_l_q;
  assign ctl.chg_ack = chg_ack_q;
  assign ctl.chg_err = chg_err_q;
  assign ctl.busy    = busy_q;

endmodule

// File: tb/tb_ctu_clsp_clkgn_divctl.sv
// Self-checking bench for ctu_clsp_clkgn_divctl. A transaction-level model
// predicts each request's outcome from the documented phase lengths and
// latency formula; outputs are compared on the falling clock edge.
module tb_ctu_clsp_clkgn_divctl;
  localparam int          S      = 4;
  localparam int          I      = 2;
  localparam int          A      = 2;
  localparam int          TMO    = 16;
  localparam logic [14:0] RST_DD = 15'h0000;

  logic        pll_clk = 1'b0;
  logic        rst_l   = 1'b1;
  logic        align_edge = 1'b0;
  logic [14:0] div_dec;
  logic        stretch_l;
  logic        init_l;

  int          n_checks;
  int          n_fail;
  logic [14:0] exp_div;

  ctu_clsp_clkgn_divctl_if req_if ();

  ctu_clsp_clkgn_divctl #(
    .STRETCH_CYC (S),
    .INIT_CYC    (I),
    .ALIGN_EDGES (A),
    .RST_DIV_DEC (RST_DD),
    .TMO_CYC     (TMO)
  ) dut (
    .pll_clk    (pll_clk),
    .rst_l      (rst_l),
    .ctl        (req_if),
    .align_edge (align_edge),
    .div_dec    (div_dec),
    .stretch_l  (stretch_l),
    .init_l     (init_l)
  );

  always #5 pll_clk = ~pll_clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Each select group may carry at most one set bit.
  function automatic bit legal(input logic [14:0] d);
    return ($countones(d[11:9]) <= 1) && ($countones(d[4:1]) <= 1) &&
           ($countones(d[8:5]) <= 1);
  endfunction

  function automatic logic next_align(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 2) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [14:0] rand_legal();
    logic [14:0] d;
    d = 15'($urandom) & 15'h7001;
    if ($urandom_range(0, 3) != 0) d[9 + $urandom_range(0, 2)] = 1'b1;
    if ($urandom_range(0, 3) != 0) d[1 + $urandom_range(0, 3)] = 1'b1;
    if ($urandom_range(0, 3) != 0) d[5 + $urandom_range(0, 3)] = 1'b1;
    return d;
  endfunction

  // Asynchronous reset between clock edges, then the boot init pulse.
  task automatic do_reset();
    #2;
    rst_l = 1'b0;
    req_if.chg_req = 1'b0;
    align_edge = 1'b0;
    #1;
    check("rst_ack",       req_if.chg_ack, 1'b0);
    check("rst_err",       req_if.chg_err, 1'b0);
    check("rst_busy",      req_if.busy,    1'b1);
    check("rst_div_dec",   div_dec,        RST_DD);
    check("rst_init_l",    init_l,         1'b0);
    check("rst_stretch_l", stretch_l,      1'b1);
    exp_div = RST_DD;
    @(negedge pll_clk);
    rst_l = 1'b1;
    for (int j = 1; j <= I + 2; j++) begin
      @(negedge pll_clk);
      check("boot_init_l",    init_l,         (j >= I));
      check("boot_busy",      req_if.busy,    (j < I));
      check("boot_stretch_l", stretch_l,      1'b1);
      check("boot_div_dec",   div_dec,        exp_div);
      check("boot_ack",       req_if.chg_ack, 1'b0);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int j = 0; j < n; j++) begin
      align_edge = 1'b1 & 1'($urandom_range(0, 1));
      @(negedge pll_clk);
      check("idle_busy", req_if.busy,    1'b0);
      check("idle_ack",  req_if.chg_ack, 1'b0);
    end
  endtask

  // One request, called on a falling edge with the sequencer idle. Edge k=0
  // is the rising edge on which IDLE samples chg_req.
  task automatic run_req(input logic [14:0] d, input int align_mode,
                         input int drop_k, input int abort_k, input int max_k);
    bit   lg;
    bit   exp_err;
    int   ack_edge;
    int   exit_edge;
    int   cnt;
    int   hold_dly;
    int   wait_start;
    logic req_at;
    logic al_at;

    lg         = legal(d);
    exp_err    = !lg;
    ack_edge   = lg ? -1 : 2;
    exit_edge  = -1;
    cnt        = 0;
    hold_dly   = $urandom_range(0, 3);
    wait_start = S + I + 2;

    check("pre_req_busy", req_if.busy, 1'b0);
    req_if.chg_req     = 1'b1;
    req_if.chg_div_dec = d;
    align_edge         = next_align(align_mode);

    for (int k = 0; k < max_k; k++) begin
      @(posedge pll_clk);
      req_at = req_if.chg_req;
      al_at  = align_edge;
      if (lg && ack_edge < 0 && k >= wait_start) begin
        if (al_at) cnt++;
        if (cnt == A) begin
          ack_edge = k + 1;
          exp_err  = 1'b0;
        end
`ifdef CTU_DIVCTL_TIMEOUT_EN
        else if (k - wait_start + 1 == TMO) begin
          ack_edge = k + 1;
          exp_err  = 1'b1;
        end
`endif
      end
      if (ack_edge >= 0 && k > ack_edge && !req_at && exit_edge < 0) exit_edge = k;
      if (lg && k == S + 1) exp_div = d;

      @(negedge pll_clk);
      check("ack", req_if.chg_ack, (k == ack_edge));
      if (k == ack_edge) check("err", req_if.chg_err, exp_err);
      check("busy",      req_if.busy, (exit_edge < 0));
      check("stretch_l", stretch_l,   !(lg && k >= 1 && k <= S + I));
      check("init_l",    init_l,      !(lg && k >= S + 1 && k <= S + I));
      check("div_dec",   div_dec,     exp_div);
      if (exit_edge >= 0) return;
      if (k == abort_k) begin
        do_reset();
        return;
      end
      req_if.chg_div_dec = 15'($urandom);
      req_if.chg_req = !((drop_k >= 0 && k + 1 >= drop_k) ||
                         (ack_edge >= 0 && k + 1 > ack_edge + hold_dly));
      align_edge = next_align(align_mode);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_div  = RST_DD;
    req_if.chg_req     = 1'b0;
    req_if.chg_div_dec = 15'd0;
    @(negedge pll_clk);
    do_reset();

    // Legal change, align_edge held high.
    run_req(15'h0842, 2, -1, -1, 200);
    idle_cycles(2);
    // Illegal group {1,2}: rejected, divider untouched.
    run_req(15'h0006, 1, -1, -1, 200);
    idle_cycles(1);
    // Requester drops chg_req during STRETCH.
    run_req(15'h0420, 1, 2, -1, 500);
    // Reset asserted during LOAD.
    run_req(15'h0884, 2, -1, S + 2, 200);
    // No alignment edges: watchdog error if built in, otherwise no ack.
    run_req(15'h0102, 0, -1, -1, 1000);
    do_reset();

    for (int t = 0; t < 30; t++) begin
      logic [14:0] d;
      int          drop;
      d    = ($urandom_range(0, 1) == 1) ? rand_legal() : 15'($urandom);
      drop = ($urandom_range(0, 1) == 1) ? -1 : int'($urandom_range(1, S + I + 3));
      run_req(d, int'($urandom_range(1, 2)), drop, -1, 2000);
      idle_cycles(int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end
endmodule
